// File: rtl/srl_pkg.sv
// Shared types and constants for the serial deserializer.
package srl_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bit-count register width; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/srl_deser.sv
// Serial-to-parallel deserializer: framed bits -> WIDTH-bit words behind a
// valid/ready output register, with sticky overflow and resync pulse.
module srl_deser
  import srl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  input  logic                    id,
  input  logic                    ien,
  input  logic                    isof,
  input  logic                    iready,
  output logic [WIDTH-1:0]        oq,
  output logic                    ovalid,
  output logic                    oovf,
  output logic                    osync_err,
  output logic [cnt_w(WIDTH)-1:0] obitcnt
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
    $error("srl_deser: WIDTH out of range");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, base, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             complete, resync;

  // Next-state, shift and completion decode; a new frame always shifts into
  // a cleared register so stale bits never leak into the word.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    resync   = 1'b0;
    base     = (isof || cnt_q == '0) ? '0 : sreg_q;
    shifted  = MSB_FIRST ? {base[WIDTH-2:0], id} : {id, base[WIDTH-1:1]};
    case (state_q)
      IDLE: begin
        if (ien && isof) begin
          sreg_d  = shifted;
          cnt_d   = ONE;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ien) begin
          sreg_d = shifted;
          if (isof && cnt_q != '0) begin
            resync = 1'b1;
            cnt_d  = ONE;
          end else if (cnt_q == LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame state, shift register and bit counter.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output word register with handshake, overflow and resync flags.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      oq        <= '0;
      ovalid    <= 1'b0;
      oovf      <= 1'b0;
      osync_err <= 1'b0;
    end else begin
      osync_err <= resync;
      if (complete && ovalid && !iready) begin
        oovf <= 1'b1;
      end else if (complete) begin
        oq     <= shifted;
        ovalid <= 1'b1;
      end else if (ovalid && iready) begin
        ovalid <= 1'b0;
      end
    end
  end

  assign obitcnt = cnt_q;

endmodule

// File: tb/tb_srl_deser.sv
// Directed bench for srl_deser: one MSB-first and one LSB-first instance on a
// shared bit stream, words checked against a queue scoreboard on acceptance.
module tb_srl_deser;

  logic       clk = 1'b0;
  logic       irst_n, id, ien, isof, iready;
  logic [7:0] oq_m, oq_l;
  logic       ovalid_m, ovalid_l, oovf_m, oovf_l, serr_m, serr_l;
  logic [2:0] cnt_m, cnt_l;

  int         pass = 0;
  int         total = 0;
  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];

  always #5 clk = ~clk;

  srl_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .iclk(clk), .irst_n(irst_n), .id(id), .ien(ien), .isof(isof), .iready(iready),
    .oq(oq_m), .ovalid(ovalid_m), .oovf(oovf_m), .osync_err(serr_m), .obitcnt(cnt_m)
  );

  srl_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .iclk(clk), .irst_n(irst_n), .id(id), .ien(ien), .isof(isof), .iready(iready),
    .oq(oq_l), .ovalid(ovalid_l), .oovf(oovf_l), .osync_err(serr_l), .obitcnt(cnt_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop and compare each word on the cycle it is accepted.
  always @(negedge clk) begin
    if (irst_n && ovalid_m && iready) begin
      chk("sb_nonempty", exp_m.size() != 0 && exp_l.size() != 0, 1);
      if (exp_m.size() != 0) chk("word_msb", oq_m, exp_m.pop_front());
      if (exp_l.size() != 0) chk("word_lsb", oq_l, exp_l.pop_front());
      chk("ovalid_lsb_match", ovalid_l, 1);
    end
  end

  // Drive n bits at full rate, isof on the first when requested.
  task automatic send_bits(input int n, input bit sof);
    for (int i = 0; i < n; i++) begin
      id = i[0]; ien = 1'b1; isof = sof && (i == 0);
      step();
    end
    ien = 1'b0; isof = 1'b0;
  endtask

  // Drive one word first-bit-first with `gap` idle cycles between bits.
  task automatic send_word(input logic [7:0] w, input bit sof, input int gap,
                           input bit serr, input bit push);
    if (push) begin
      exp_m.push_back(w);
      exp_l.push_back(rev8(w));
    end
    for (int i = 0; i < 8; i++) begin
      id = w[7-i]; ien = 1'b1; isof = sof && (i == 0);
      step();
      ien = 1'b0; isof = 1'b0;
      if (sof && i == 0) begin
        chk("bitcnt_sof", cnt_m, 1);
        chk("sync_err", serr_m, serr);
      end
      if (i == 1) chk("sync_err_clr", serr_m, 0);
      if (i == 6) chk("bitcnt_pre_last", cnt_m, 7);
      if (i < 7) repeat (gap) step();
    end
    chk("ovalid_done", ovalid_m, 1);
    chk("bitcnt_wrap", cnt_m, 0);
  endtask

  initial begin
    irst_n = 1'b0; id = 1'b0; ien = 1'b0; isof = 1'b0; iready = 1'b1;
    step(); step();
    chk("rst_oq", {oq_m, oq_l}, 0);
    chk("rst_flags", {ovalid_m, oovf_m, serr_m, ovalid_l, oovf_l, serr_l}, 0);
    chk("rst_cnt", {cnt_m, cnt_l}, 0);
    irst_n = 1'b1;
    step();

    // Full-rate word then a contiguous word without isof.
    send_word(8'hC0, 1'b1, 0, 1'b0, 1'b1);
    send_word(8'hA5, 1'b0, 0, 1'b0, 1'b1);
    step(); step();
    chk("ovalid_drained", ovalid_m, 0);

    // Overflow: second word dropped while the first waits.
    iready = 1'b0;
    send_word(8'h11, 1'b1, 0, 1'b0, 1'b1);
    chk("oovf_before", oovf_m, 0);
    send_word(8'h22, 1'b0, 0, 1'b0, 1'b0);
    chk("oovf_set", {oovf_m, oovf_l}, 2'b11);
    chk("ovf_oq_held_msb", oq_m, 8'h11);
    chk("ovf_oq_held_lsb", oq_l, 8'h88);
    iready = 1'b1;
    step();
    chk("ovalid_after_accept", ovalid_m, 0);
    chk("oovf_sticky", oovf_m, 1);

    // Mid-word resync at count 3.
    send_bits(3, 1'b1);
    chk("bitcnt_partial", cnt_m, 3);
    chk("no_sync_err_at_boundary", serr_m, 0);
    send_word(8'h96, 1'b1, 0, 1'b1, 1'b1);

    // ien toggling 1,0,...: word completes after 15 cycles.
    send_word(8'h3C, 1'b1, 1, 1'b0, 1'b1);
    step();

    // Reset mid-word with a word pending.
    iready = 1'b0;
    send_word(8'h77, 1'b1, 0, 1'b0, 1'b1);
    send_bits(5, 1'b0);
    chk("bitcnt_5", cnt_m, 5);
    irst_n = 1'b0; id = 1'b1; ien = 1'b1; isof = 1'b1;
    step();
    chk("midrst_oq", {oq_m, oq_l}, 0);
    chk("midrst_flags", {ovalid_m, oovf_m, serr_m, ovalid_l, oovf_l, serr_l}, 0);
    chk("midrst_cnt", {cnt_m, cnt_l}, 0);
    exp_m.delete(); exp_l.delete();
    irst_n = 1'b1; ien = 1'b0; isof = 1'b0; iready = 1'b1;
    step();

    // ien without isof in IDLE is ignored.
    send_bits(8, 1'b0);
    chk("idle_no_valid", ovalid_m, 0);
    chk("idle_no_count", cnt_m, 0);
    send_word(8'hE1, 1'b1, 0, 1'b0, 1'b1);
    step(); step(); step();
    chk("sb_drained", exp_m.size() + exp_l.size(), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
